uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte producers using round-robin arbitration.
- Sits between producer blocks (command responder, debug/status dumpers) and the single uart_tx instance.
- Latches the winner's byte, issues a one-cycle start to the transmitter, and tracks the transmitter's busy flag until the frame completes.
- Enforces an optional inter-frame idle gap before the next grant.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 8: byte width.
- GAP_CYCLES, 0: idle clk cycles inserted after tx_busy falls (0 = no gap).
- TIMEOUT_CYCLES, 65535: watchdog limit per wait state; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester byte-pending flag; level, held until ack.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i owns bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-cycle pulse; byte of requester i has been latched.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  DATA_W  byte to transmit; stable from tx_start until return to IDLE.
- tx_busy  in  1  transmitter busy; high for the whole frame.
- grant_id  out  clog2(NUM_REQ)  index of the current/last granted requester.
- arb_busy  out  1  high in every state except IDLE.
- err_timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (sync, active-high): state IDLE; ack=0, tx_start=0, tx_data=0, grant_id=0, arb_busy=0, err_timeout=0, gap counter=0, last_grant=NUM_REQ-1 (requester 0 has top priority first). Reset mid-frame aborts immediately; no ack or tx_start is issued after the reset cycle.
- States:
  - IDLE: if req!=0 at cycle t, select the first set bit searching from last_grant+1 upward with wrap.
    - Register grant_id, last_grant and tx_data=req_data[sel].
    - Assert ack[sel] and go to LAUNCH; both ack[sel] and tx_start are high in cycle t+1.
    - If req==0, stay in IDLE.
  - LAUNCH (1 cycle): tx_start=1; go to WAIT_BUSY.
  - WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until tx_busy=0. If GAP_CYCLES==0 go to IDLE, else load the counter and go to GAP.
  - GAP: decrement the counter each cycle; go to IDLE when it reaches 1. GAP therefore lasts exactly GAP_CYCLES cycles.
- Exactly one ack bit is high at a time, and only in the LAUNCH cycle.
- A requester must deassert req, or present a new byte, by the cycle after ack. A req still high when IDLE next samples is treated as a new request.
- req changes while the arbiter is not in IDLE are ignored. A request arriving during GAP is granted on the first IDLE cycle.
- Fairness: with all req bits held high, grants rotate 0,1,2,...,NUM_REQ-1,0. Only requesters after last_grant in rotation beat lower indices.
- tx_busy already high in LAUNCH is legal; WAIT_BUSY exits on the next cycle.
- Minimum frame-to-frame spacing is LAUNCH + WAIT_BUSY + busy time + GAP_CYCLES + 1 IDLE cycle.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined: a watchdog counter clears on entry to WAIT_BUSY and on entry to WAIT_DONE and increments each cycle in those states. On reaching TIMEOUT_CYCLES the arbiter goes to IDLE (no GAP) and pulses err_timeout for one cycle. last_grant keeps the aborted requester; its byte is not retried.
- Not defined: no watchdog logic; wait states block indefinitely; err_timeout is tied to 0.

Decomposition:
- Package uart_pkg:
  - arbiter state encoding (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP);
  - UART_DATA_W=8;
  - a clog2 helper function.
- Sub-module rr_pick: purely combinational rotate-priority selector. Inputs req and last_grant; outputs sel index and a valid flag. Reusable for future RX-side fan-out.

Test Plan:
- Single request: req=4'b0100, data 8'hA5; tx model raises busy 2 cycles after tx_start for 10 cycles -> ack[2] and tx_start in the same cycle, tx_data=8'hA5, grant_id=2, arb_busy low the cycle after busy falls.
- Rotation: all req held high, requester i sends 8'h10+i -> tx_data sequence 10,11,12,13,10; each ack pulses exactly once per grant.
- Gap: GAP_CYCLES=3, two back-to-back requests -> next tx_start occurs exactly 3+2 cycles after tx_busy falls.
- Mid-frame reset: assert reset during WAIT_DONE -> next cycle all outputs 0, state IDLE; the following grant with req=4'b1111 goes to requester 0.
- Late busy: tx_busy stays high through LAUNCH -> WAIT_BUSY lasts 1 cycle, no double tx_start.
- Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20): tx_busy never rises -> err_timeout pulses 20 cycles after entering WAIT_BUSY and arb_busy drops; without the macro, arb_busy stays high and err_timeout stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: arbiter state encoding,
// default byte width and a ceiling-log2 used to size index and counter fields.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_LAUNCH    = 3'd1,
    ARB_WAIT_BUSY = 3'd2,
    ARB_WAIT_DONE = 3'd3,
    ARB_GAP       = 3'd4
  } arb_state_e;

  // Bits needed to hold values 0..value-1; never less than 1 so fields stay legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (64'(value) > (64'(1) << i)) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority selector: first set request strictly after
// i_last_grant, searching upward with wrap-around.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last_grant,
  output logic [IW-1:0] o_sel_c,
  output logic          o_valid_c
);

  // Scan farthest-first so the nearest requester after last_grant wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    o_sel_c   = '0;
    o_valid_c = 1'b0;
    for (int unsigned k = N; k > 0; k--) begin
      idx = 32'(i_last_grant) + k;
      if (idx >= N) idx = idx - N;
      if (i_req[idx[IW-1:0]]) begin
        o_sel_c   = idx[IW-1:0];
        o_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_ARB_TIMEOUT_EN to add a watchdog on the transmitter busy handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned DATA_W         = UART_DATA_W,
  parameter  int unsigned GAP_CYCLES     = 0,
  parameter  int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned ID_W           = clog2(NUM_REQ)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]          o_ack,
  output logic                        o_tx_start,
  output logic [DATA_W-1:0]           o_tx_data,
  input  logic                        i_tx_busy,
  output logic [ID_W-1:0]             o_grant_id,
  output logic                        o_arb_busy,
  output logic                        o_err_timeout
);

  localparam int unsigned GAP_W = clog2(GAP_CYCLES + 1);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [NUM_REQ-1:0]  r_ack;
  logic [NUM_REQ-1:0]  w_ack_nxt;
  logic                r_tx_start;
  logic                w_tx_start_nxt;
  logic [DATA_W-1:0]   r_tx_data;
  logic [DATA_W-1:0]   w_tx_data_nxt;
  logic [ID_W-1:0]     r_grant_id;
  logic [ID_W-1:0]     w_grant_id_nxt;
  logic [ID_W-1:0]     r_last_grant;
  logic [ID_W-1:0]     w_last_grant_nxt;
  logic                r_arb_busy;
  logic                w_arb_busy_nxt;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [GAP_W-1:0]    w_gap_cnt_nxt;
  logic [ID_W-1:0]     w_sel;
  logic                w_sel_valid;
  logic [DATA_W-1:0]   w_bytes [NUM_REQ];

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0]     r_wd_cnt;
  logic [TO_W-1:0]     w_wd_cnt_nxt;
  logic                r_err_timeout;
  logic                w_err_timeout_nxt;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_bytes[g] = i_req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .i_req        (i_req),
    .i_last_grant (r_last_grant),
    .o_sel_c      (w_sel),
    .o_valid_c    (w_sel_valid)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_ack_nxt        = '0;
    w_tx_start_nxt   = 1'b0;
    w_tx_data_nxt    = r_tx_data;
    w_grant_id_nxt   = r_grant_id;
    w_last_grant_nxt = r_last_grant;
    w_gap_cnt_nxt    = r_gap_cnt;
`ifdef UART_ARB_TIMEOUT_EN
    w_wd_cnt_nxt      = '0;
    w_err_timeout_nxt = 1'b0;
`endif

    unique case (r_state)
      ARB_IDLE: begin
        if (w_sel_valid) begin
          w_state_nxt       = ARB_LAUNCH;
          w_ack_nxt[w_sel]  = 1'b1;
          w_tx_start_nxt    = 1'b1;
          w_tx_data_nxt     = w_bytes[w_sel];
          w_grant_id_nxt    = w_sel;
          w_last_grant_nxt  = w_sel;
        end
      end
      ARB_LAUNCH: begin
        w_state_nxt = ARB_WAIT_BUSY;
      end
      ARB_WAIT_BUSY: begin
        if (i_tx_busy) w_state_nxt = ARB_WAIT_DONE;
      end
      ARB_WAIT_DONE: begin
        if (!i_tx_busy) begin
          if (GAP_CYCLES == 0) begin
            w_state_nxt = ARB_IDLE;
          end else begin
            w_state_nxt   = ARB_GAP;
            w_gap_cnt_nxt = GAP_W'(GAP_CYCLES);
          end
        end
      end
      ARB_GAP: begin
        if (r_gap_cnt <= GAP_W'(1)) begin
          w_state_nxt   = ARB_IDLE;
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase

`ifdef UART_ARB_TIMEOUT_EN
    // Count only while still parked in a wait state; any transition clears it.
    if ((r_state == ARB_WAIT_BUSY || r_state == ARB_WAIT_DONE) && (w_state_nxt == r_state)) begin
      if (r_wd_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        w_state_nxt       = ARB_IDLE;
        w_err_timeout_nxt = 1'b1;
      end else begin
        w_wd_cnt_nxt = r_wd_cnt + TO_W'(1);
      end
    end
`endif

    w_arb_busy_nxt = (w_state_nxt != ARB_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ARB_IDLE;
      r_ack        <= '0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
      r_grant_id   <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_arb_busy   <= 1'b0;
      r_gap_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ack        <= w_ack_nxt;
      r_tx_start   <= w_tx_start_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_arb_busy   <= w_arb_busy_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wd_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_wd_cnt      <= w_wd_cnt_nxt;
      r_err_timeout <= w_err_timeout_nxt;
    end
  end

  assign o_err_timeout = r_err_timeout;
`else
  assign o_err_timeout = 1'b0;
`endif

  assign o_ack      = r_ack;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_grant_id = r_grant_id;
  assign o_arb_busy = r_arb_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (GAP_CYCLES=3, TIMEOUT_CYCLES=20);
// covers both builds of UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 3;
  localparam int TO  = 20;

  logic            clk = 1'b0;
  logic            i_reset;
  logic [N-1:0]    i_req;
  logic [N*DW-1:0] i_req_data;
  logic            i_tx_busy;
  logic [N-1:0]    o_ack;
  logic            o_tx_start;
  logic [DW-1:0]   o_tx_data;
  logic [1:0]      o_grant_id;
  logic            o_arb_busy;
  logic            o_err_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int m_last;
  logic [DW-1:0] dat [N];

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .DATA_W         (DW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_req         (i_req),
    .i_req_data    (i_req_data),
    .o_ack         (o_ack),
    .o_tx_start    (o_tx_start),
    .o_tx_data     (o_tx_data),
    .i_tx_busy     (i_tx_busy),
    .o_grant_id    (o_grant_id),
    .o_arb_busy    (o_arb_busy),
    .o_err_timeout (o_err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rotation: nearest set requester after the last grant, with wrap.
  function automatic int model_pick(input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic pack_data();
    for (int i = 0; i < N; i++) i_req_data[i*DW +: DW] = dat[i];
  endtask

  // One frame starting at a negedge where the arbiter is idle; busy is driven
  // high from negedge k to negedge k+len. Ends at the negedge where idle returns.
  task automatic frame(input logic [N-1:0] mask, input int k, input int len, input bit scramble);
    int sel;
    int b;
    logic [DW-1:0] exp_data;
    sel      = model_pick(mask);
    exp_data = dat[sel];
    b        = k + len;
    i_req    = mask;
    pack_data();
    i_tx_busy = (k == 0);
    for (int c = 1; c <= b + GAP + 1; c++) begin
      @(negedge clk);
      chk("ack",         32'(o_ack),         (c == 1) ? (32'(1) << sel) : 32'(0));
      chk("tx_start",    32'(o_tx_start),    32'(c == 1));
      chk("tx_data",     32'(o_tx_data),     32'(exp_data));
      chk("grant_id",    32'(o_grant_id),    32'(sel));
      chk("arb_busy",    32'(o_arb_busy),    32'(c <= b + GAP));
      chk("err_timeout", 32'(o_err_timeout), 32'(0));
      i_tx_busy = (c >= k) && (c < b);
      if (scramble && c < b + GAP + 1) i_req = N'($urandom);
    end
    m_last = sel;
  endtask

  initial begin
    int sel;
    i_reset    = 1'b1;
    i_req      = '0;
    i_req_data = '0;
    i_tx_busy  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack",      32'(o_ack),         32'(0));
    chk("rst_tx_start", 32'(o_tx_start),    32'(0));
    chk("rst_tx_data",  32'(o_tx_data),     32'(0));
    chk("rst_grant_id", 32'(o_grant_id),    32'(0));
    chk("rst_arb_busy", 32'(o_arb_busy),    32'(0));
    chk("rst_err",      32'(o_err_timeout), 32'(0));
    i_reset = 1'b0;
    m_last  = N - 1;

    // Rotation with every request held high: 10,11,12,13,10.
    for (int i = 0; i < N; i++) dat[i] = DW'(8'h10 + i);
    for (int r = 0; r < 5; r++) frame(4'b1111, 1, 4, 1'b0);

    // Single requester, busy two cycles after tx_start for ten cycles.
    for (int i = 0; i < N; i++) dat[i] = DW'($urandom);
    dat[2] = 8'hA5;
    frame(4'b0100, 3, 10, 1'b0);

    // Busy already high while LAUNCH is presented.
    frame(4'b1000, 0, 4, 1'b0);

    // Randomized traffic with request noise while the arbiter is busy.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) dat[i] = DW'($urandom);
      frame(N'($urandom_range(1, 15)), $urandom_range(0, 4), $urandom_range(3, 12), 1'b1);
    end

    // Reset asserted while waiting for the frame to complete.
    for (int i = 0; i < N; i++) dat[i] = DW'($urandom);
    sel   = model_pick(4'b0110);
    i_req = 4'b0110;
    pack_data();
    @(negedge clk);
    chk("mrst_ack", 32'(o_ack), 32'(1) << sel);
    i_tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    i_req   = 4'b1111;
    @(negedge clk);
    chk("mrst_ack0",      32'(o_ack),         32'(0));
    chk("mrst_tx_start0", 32'(o_tx_start),    32'(0));
    chk("mrst_tx_data0",  32'(o_tx_data),     32'(0));
    chk("mrst_grant0",    32'(o_grant_id),    32'(0));
    chk("mrst_busy0",     32'(o_arb_busy),    32'(0));
    chk("mrst_err0",      32'(o_err_timeout), 32'(0));
    i_reset   = 1'b0;
    i_tx_busy = 1'b0;
    m_last    = N - 1;
    frame(4'b1111, 2, 5, 1'b0);

    // Transmitter never raises busy.
    sel   = model_pick(4'b0010);
    i_req = 4'b0010;
    pack_data();
    i_tx_busy = 1'b0;
    @(negedge clk);
    chk("to_ack",      32'(o_ack),      32'(1) << sel);
    chk("to_tx_start", 32'(o_tx_start), 32'(1));
    chk("to_tx_data",  32'(o_tx_data),  32'(dat[sel]));
    i_req = '0;
`ifdef UART_ARB_TIMEOUT_EN
    for (int c = 2; c <= TO + 1; c++) begin
      @(negedge clk);
      chk("to_busy_wait", 32'(o_arb_busy),    32'(1));
      chk("to_err_wait",  32'(o_err_timeout), 32'(0));
    end
    @(negedge clk);
    chk("to_err_pulse", 32'(o_err_timeout), 32'(1));
    chk("to_busy_drop", 32'(o_arb_busy),    32'(0));
    @(negedge clk);
    chk("to_err_clear", 32'(o_err_timeout), 32'(0));
    chk("to_idle",      32'(o_arb_busy),    32'(0));
`else
    for (int c = 2; c <= 41; c++) begin
      @(negedge clk);
      chk("nto_busy_hold", 32'(o_arb_busy),    32'(1));
      chk("nto_err_zero",  32'(o_err_timeout), 32'(0));
    end
    i_tx_busy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("nto_busy_frame", 32'(o_arb_busy), 32'(1));
    end
    i_tx_busy = 1'b0;
    for (int j = 1; j <= GAP + 1; j++) begin
      @(negedge clk);
      chk("nto_gap", 32'(o_arb_busy), 32'(j <= GAP));
    end
`endif
    m_last = sel;

    // Requests after the watchdog case still follow rotation.
    for (int i = 0; i < N; i++) dat[i] = DW'($urandom);
    frame(4'b1111, 1, 3, 1'b0);

    // No request: stays idle.
    i_req = '0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(o_arb_busy), 32'(0));
    chk("idle_ack",  32'(o_ack),      32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
